// File: rtl/mul_iter_unit.sv
// mul_iter_unit
// Multi-cycle radix-2 shift-add multiply / multiply-accumulate unit for the EX stage.
// Operands are reduced to magnitudes, multiplied one multiplier bit per cycle, then the
// sign is restored and, optionally, the product is added to an accumulator with signed
// saturation. The upstream pipeline is stalled while the unit iterates.
//
// Ports:
//   clk        clock, rising edge
//   res        synchronous active-high reset
//   start      request, sampled only in IDLE
//   signed_op  1 = two's complement operands, 0 = unsigned
//   acc_en     1 = add product to acc_in with signed saturation
//   op_a       multiplicand
//   op_b       multiplier
//   acc_in     accumulator value
//   busy       high in CALC and FIX
//   stall      busy, or a start request seen in IDLE
//   done       one-cycle pulse, product/sat valid
//   product    2*WIDTH result, held until the next completion
//   sat        saturation flag for the held product
module mul_iter_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 start,
   input  logic                 signed_op,
   input  logic                 acc_en,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   input  logic [2*WIDTH-1:0]   acc_in,
   output logic                 busy,
   output logic                 stall,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic                 sat
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [PW-1:0]     partial_q, partial_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              neg_q, neg_d;
   logic              acc_en_q, acc_en_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     product_q, product_d;
   logic              sat_q, sat_d;

   // Datapath helpers
   logic [WIDTH-1:0]  mag_a, mag_b;
   logic [WIDTH:0]    add_sum;
   logic [PW-1:0]     fix_p, sum_s;
   logic              pos_ovf, neg_ovf;

   // The magnitude of the most negative value fits exactly as an unsigned WIDTH-bit number.
   assign mag_a = (signed_op && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
   assign mag_b = (signed_op && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;

   // Carry out of the upper-half add is kept as bit WIDTH and shifted back in.
   assign add_sum = {1'b0, partial_q[PW-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

   assign fix_p   = neg_q ? (~partial_q + 1'b1) : partial_q;
   assign sum_s   = acc_q + fix_p;
   // Overflow only when both addends share a sign that the sum does not.
   assign pos_ovf = ~acc_q[PW-1] & ~fix_p[PW-1] &  sum_s[PW-1];
   assign neg_ovf =  acc_q[PW-1] &  fix_p[PW-1] & ~sum_s[PW-1];

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      partial_d = partial_q;
      count_d   = count_q;
      neg_d     = neg_q;
      acc_en_d  = acc_en_q;
      acc_d     = acc_q;
      product_d = product_q;
      sat_d     = sat_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               mcand_d   = mag_a;
               mplier_d  = mag_b;
               neg_d     = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
               acc_en_d  = acc_en;
               acc_d     = acc_in;
               partial_d = '0;
               count_d   = '0;
               state_d   = StCalc;
            end
         end
         StCalc: begin
            partial_d = {add_sum, partial_q[WIDTH-1:1]};
            mplier_d  = mplier_q >> 1;
            count_d   = count_q + 1'b1;
            if (count_q == CntW'(WIDTH - 1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            if (!acc_en_q) begin
               product_d = fix_p;
               sat_d     = 1'b0;
            end else if (pos_ovf) begin
               product_d = {1'b0, {(PW-1){1'b1}}};
               sat_d     = 1'b1;
            end else if (neg_ovf) begin
               product_d = {1'b1, {(PW-1){1'b0}}};
               sat_d     = 1'b1;
            end else begin
               product_d = sum_s;
               sat_d     = 1'b0;
            end
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         mplier_q  <= '0;
         partial_q <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         acc_en_q  <= 1'b0;
         acc_q     <= '0;
         product_q <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         partial_q <= partial_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         acc_en_q  <= acc_en_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         sat_q     <= sat_d;
      end
   end

   assign busy    = (state_q == StCalc) || (state_q == StFix);
   assign stall   = busy | (start & (state_q == StIdle));
   assign done    = (state_q == StDone);
   assign product = product_q;
   assign sat     = sat_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Self-checking bench for mul_iter_unit (WIDTH = 32). Expected results are produced by a
// 65-bit reference model and queued at request time; a monitor pops them on each done.
module tb_mul_iter_unit;

   localparam int unsigned W   = 32;
   localparam int          LAT = 34;
   localparam int          THR = 35;

   logic          clk;
   logic          res;
   logic          start;
   logic          signed_op;
   logic          acc_en;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [63:0]   acc_in;
   logic          busy;
   logic          stall;
   logic          done;
   logic [63:0]   product;
   logic          sat;

   typedef struct {
      logic [63:0] p;
      logic        s;
      int          t0;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   logic        mon_en = 1'b0;
   logic [63:0] held_p = '0;
   logic        held_s = 1'b0;

   mul_iter_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .res       (res),
      .start     (start),
      .signed_op (signed_op),
      .acc_en    (acc_en),
      .op_a      (op_a),
      .op_b      (op_b),
      .acc_in    (acc_in),
      .busy      (busy),
      .stall     (stall),
      .done      (done),
      .product   (product),
      .sat       (sat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  input logic ae, input logic [63:0] acc);
      exp_t               e;
      logic [63:0]        ea, eb, p;
      logic signed [64:0] w;
      ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      e.t0 = 0;
      if (!ae) begin
         e.p = p;
         e.s = 1'b0;
      end else begin
         w = $signed({acc[63], acc}) + $signed({p[63], p});
         if (w[64] != w[63]) begin
            e.p = w[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
            e.s = 1'b1;
         end else begin
            e.p = w[63:0];
            e.s = 1'b0;
         end
      end
      return e;
   endfunction

   // Monitor: score completions and make sure results hold between them.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (res) begin
            held_p <= '0;
            held_s <= 1'b0;
         end else if (done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("product", product, e.p);
               check("sat", {63'b0, sat}, {63'b0, e.s});
               check("latency", 64'(cyc - e.t0), 64'(LAT));
            end
            held_p <= product;
            held_s <= sat;
         end else begin
            check("hold_product", product, held_p);
            check("hold_sat", {63'b0, sat}, {63'b0, held_s});
         end
      end
   end

   task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic ae, input logic [63:0] acc);
      exp_t e;
      e    = model(a, b, sgn, ae, acc);
      e.t0 = cyc;
      sb.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 3 * LAT && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   // Called at a negedge with the unit in IDLE.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic ae, input logic [63:0] acc);
      op_a      = a;
      op_b      = b;
      signed_op = sgn;
      acc_en    = ae;
      acc_in    = acc;
      start     = 1'b1;
      push_exp(a, b, sgn, ae, acc);
      #1;
      check("stall_on_start", {63'b0, stall}, 64'd1);
      check("busy_in_idle", {63'b0, busy}, 64'd0);
      @(negedge clk);
      // Scramble inputs after sampling; they must not affect the result.
      start     = 1'b0;
      op_a      = $urandom;
      op_b      = $urandom;
      acc_in    = {$urandom, $urandom};
      signed_op = ~sgn;
      acc_en    = ~ae;
      check("busy_calc", {63'b0, busy}, 64'd1);
      drain();
   endtask

   // start held high; a new op_a is presented in each IDLE cycle.
   task automatic hs_run(input int n);
      logic [31:0] a;
      start     = 1'b1;
      signed_op = 1'b1;
      acc_en    = 1'b0;
      op_b      = 32'h0000_0135;
      acc_in    = '0;
      for (int k = 0; k < n; k++) begin
         a    = 32'h0000_1000 + 32'(k * 7) - 32'(k * 9000);
         op_a = a;
         push_exp(a, op_b, 1'b1, 1'b0, 64'd0);
         for (int j = 0; j < THR; j++) begin
            #1;
            check("hs_stall", {63'b0, stall}, {63'b0, (j != THR - 1)});
            check("hs_done", {63'b0, done}, {63'b0, (j == THR - 1)});
            @(negedge clk);
         end
      end
      start = 1'b0;
      drain();
   endtask

   initial begin
      res       = 1'b1;
      start     = 1'b0;
      signed_op = 1'b0;
      acc_en    = 1'b0;
      op_a      = '0;
      op_b      = '0;
      acc_in    = '0;
      repeat (2) @(negedge clk);
      res = 1'b0;
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_done", {63'b0, done}, 64'd0);
      check("rst_product", product, 64'd0);
      check("rst_sat", {63'b0, sat}, 64'd0);
      check("rst_stall", {63'b0, stall}, 64'd0);
      mon_en = 1'b1;

      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'd0);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 64'd0);
      do_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b0, 64'd0);
      do_op(32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFF0);
      do_op(32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 64'h0000_0000_0000_0100);
      do_op(32'hFFFF_FFF0, 32'h0000_0010, 1'b1, 1'b1, 64'h8000_0000_0000_0010);
      do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 64'd0);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 64'd0);

      // Reset in the middle of CALC discards the operation.
      op_a      = 32'h1234_5678;
      op_b      = 32'h0000_0003;
      signed_op = 1'b0;
      acc_en    = 1'b0;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      res = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("midrst_busy", {63'b0, busy}, 64'd0);
      check("midrst_done", {63'b0, done}, 64'd0);
      check("midrst_product", product, 64'd0);
      check("midrst_sat", {63'b0, sat}, 64'd0);
      res = 1'b0;
      repeat (2 * THR) @(negedge clk);

      hs_run(4);

      for (int i = 0; i < 6; i++) begin
         do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

endmodule
